shift_reg_1x64_to_4x64_sipo: RTL and testbench

Serial-in/parallel-out frame assembler. It is the receive-side counterpart of the 4x64 PISO word serializer in the ADC data acquisition path. It accepts one 64-bit ADC word per valid cycle and assembles DEPTH consecutive words into one parallel frame. The frame is presented to the downstream PMU processing stage through a valid/ready handshake.

---
 rtl/pmu_adc_pkg.sv | 18 +
 rtl/sipo_idle_timer.sv | 35 +++
 rtl/shift_reg_1x64_to_4x64_sipo.sv | 157 +++++++++++++++
 tb/tb_shift_reg_1x64_to_4x64_sipo.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_adc_pkg.sv
// Shared ADC acquisition-path types and constants.
// Used by the 4x64 PISO word serializer and the SIPO frame assembler.
package pmu_adc_pkg;

   // Default word width and frame depth of the ADC path.
   localparam int unsigned ADC_WORD_W      = 64;
   localparam int unsigned ADC_FRAME_DEPTH = 4;

   // SIPO assembler states.
   typedef enum logic [0:0] {
      COLLECT   = 1'b0,
      FULL_WAIT = 1'b1
   } sipo_state_t;

   // One frame of ADC words; element 0 is the first word in time.
   typedef logic [ADC_WORD_W-1:0] adc_frame_t [ADC_FRAME_DEPTH];

endpackage : pmu_adc_pkg

// File: rtl/sipo_idle_timer.sv
// Idle-cycle timer for the SIPO frame assembler.
// Counts consecutive cycles with idle=1.  expire_c is high in the cycle the
// count would reach TIMEOUT; the counter then returns to zero.
// Ports:
//   CLK      in   clock, posedge
//   nRST     in   synchronous active-low reset
//   idle     in   partial frame held and no word arriving this cycle
//   expire_c out  combinational: discard the partial frame this cycle
module sipo_idle_timer #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic CLK,
   input  logic nRST,
   input  logic idle,
   output logic expire_c
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] count;

   assign expire_c = idle && (count == TW'(TIMEOUT - 1));

   // Any non-idle cycle or an expiry restarts the count.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         count <= '0;
      end else if (idle && !expire_c) begin
         count <= count + TW'(1);
      end else begin
         count <= '0;
      end
   end

endmodule : sipo_idle_timer

// File: rtl/shift_reg_1x64_to_4x64_sipo.sv
// Serial-in/parallel-out ADC frame assembler: collects DEPTH words of WIDTH
// bits and hands them downstream as one frame over a valid/ready handshake.
// Optional feature macro: SIPO_TIMEOUT_EN (discard a partial frame after
// TIMEOUT idle cycles).
// Ports:
//   CLK         in   clock, posedge
//   nRST        in   synchronous active-low reset
//   DIN_VALID   in   DIN holds a word this cycle
//   DIN         in   serial word input
//   FLUSH       in   discard partial frame (ignored while a full frame waits)
//   DOUT        out  assembled frame, DOUT[0] = first word received
//   DOUT_VALID  out  frame available on DOUT
//   DOUT_READY  in   consumer accepts frame when DOUT_VALID & DOUT_READY
//   WORD_CNT    out  words held in assembly buffer
//   OVERFLOW    out  sticky: a word was dropped
module shift_reg_1x64_to_4x64_sipo
   import pmu_adc_pkg::*;
#(
   parameter int unsigned WIDTH   = ADC_WORD_W,
   parameter int unsigned DEPTH   = ADC_FRAME_DEPTH,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    DIN_VALID,
   input  logic [WIDTH-1:0]        DIN,
   input  logic                    FLUSH,
   output logic [WIDTH-1:0]        DOUT [DEPTH],
   output logic                    DOUT_VALID,
   input  logic                    DOUT_READY,
   output logic [$clog2(DEPTH):0]  WORD_CNT,
   output logic                    OVERFLOW
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   if (DEPTH < 2) begin : g_depth_chk
      $error("DEPTH must be at least 2");
   end
   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("TIMEOUT must be at least 1");
   end

   sipo_state_t      state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] asm_q    [DEPTH];
   logic [WIDTH-1:0] asm_nxt  [DEPTH];
   logic [WIDTH-1:0] dout_nxt [DEPTH];
   logic             dout_valid_nxt;
   logic             overflow_nxt;
   logic             slot_free;
   logic             timeout_fire;

`ifdef SIPO_TIMEOUT_EN
   logic idle;

   assign idle = (state == COLLECT) && (cnt != '0) && !DIN_VALID;

   sipo_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .CLK      (CLK),
      .nRST     (nRST),
      .idle     (idle),
      .expire_c (timeout_fire)
   );
`else
   assign timeout_fire = 1'b0;
`endif

   // Output register can take a new frame this cycle.
   assign slot_free = !DOUT_VALID || DOUT_READY;

   // State register and datapath registers.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state      <= COLLECT;
         cnt        <= '0;
         DOUT_VALID <= 1'b0;
         OVERFLOW   <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            asm_q[i] <= '0;
            DOUT[i]  <= '0;
         end
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         DOUT_VALID <= dout_valid_nxt;
         OVERFLOW   <= overflow_nxt;
         for (int i = 0; i < int'(DEPTH); i++) begin
            asm_q[i] <= asm_nxt[i];
            DOUT[i]  <= dout_nxt[i];
         end
      end
   end

   assign WORD_CNT = cnt;

   // Next-state and datapath decode.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      overflow_nxt   = OVERFLOW;
      asm_nxt        = asm_q;
      dout_nxt       = DOUT;
      // Handshake completes; a new frame below overrides this.
      dout_valid_nxt = DOUT_VALID && !DOUT_READY;

      unique case (state)
         COLLECT: begin
            if (FLUSH || timeout_fire) begin
               cnt_nxt = '0;
            end else if (DIN_VALID) begin
               if (cnt < CW'(DEPTH - 1)) begin
                  for (int i = 0; i < int'(DEPTH); i++) begin
                     if (cnt == CW'(i)) asm_nxt[i] = DIN;
                  end
                  cnt_nxt = cnt + CW'(1);
               end else if (slot_free) begin
                  // Last word bypasses the buffer straight into DOUT.
                  for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                     dout_nxt[i] = asm_q[i];
                  end
                  dout_nxt[DEPTH-1] = DIN;
                  dout_valid_nxt    = 1'b1;
                  cnt_nxt           = '0;
               end else begin
                  asm_nxt[DEPTH-1] = DIN;
                  cnt_nxt          = CW'(DEPTH);
                  state_nxt        = FULL_WAIT;
               end
            end
         end

         FULL_WAIT: begin
            if (DOUT_READY) begin
               dout_nxt       = asm_q;
               dout_valid_nxt = 1'b1;
               state_nxt      = COLLECT;
               if (DIN_VALID) begin
                  asm_nxt[0] = DIN;
                  cnt_nxt    = CW'(1);
               end else begin
                  cnt_nxt    = '0;
               end
            end else if (DIN_VALID) begin
               overflow_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = COLLECT;
         end
      endcase
   end

endmodule : shift_reg_1x64_to_4x64_sipo

// File: tb/tb_shift_reg_1x64_to_4x64_sipo.sv
// Self-checking bench for shift_reg_1x64_to_4x64_sipo: directed scenarios
// plus randomized traffic compared against a queue-based frame model.
module tb_shift_reg_1x64_to_4x64_sipo;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned DEPTH = 4;
`ifdef SIPO_TIMEOUT_EN
   localparam int unsigned TIMEOUT = 8;
`else
   localparam int unsigned TIMEOUT = 1024;
`endif
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             DIN_VALID;
   logic [WIDTH-1:0] DIN;
   logic             FLUSH;
   logic [WIDTH-1:0] DOUT [DEPTH];
   logic             DOUT_VALID;
   logic             DOUT_READY;
   logic [CW-1:0]    WORD_CNT;
   logic             OVERFLOW;

   int checks = 0;
   int errors = 0;

   // Reference model: words waiting to form a frame, and the output register.
   logic [WIDTH-1:0] m_q [$];
   logic [WIDTH-1:0] m_out [DEPTH];
   bit               m_valid;
   bit               m_ovf;
   int               m_idle;

   shift_reg_1x64_to_4x64_sipo #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .DIN_VALID  (DIN_VALID),
      .DIN        (DIN),
      .FLUSH      (FLUSH),
      .DOUT       (DOUT),
      .DOUT_VALID (DOUT_VALID),
      .DOUT_READY (DOUT_READY),
      .WORD_CNT   (WORD_CNT),
      .OVERFLOW   (OVERFLOW)
   );

   always #5 CLK = ~CLK;

   function automatic logic [WIDTH-1:0] pat(input int unsigned n);
      return 64'h1111_1111_1111_1111 * 64'(n);
   endfunction

   // Frame-level model of one clock edge.
   function automatic void model_edge(input bit rst_n, input bit dv, input bit fl,
                                      input bit rdy, input logic [WIDTH-1:0] d);
      bit free;
      bit fire;
      if (!rst_n) begin
         m_q.delete();
         foreach (m_out[i]) m_out[i] = '0;
         m_valid = 0;
         m_ovf   = 0;
         m_idle  = 0;
         return;
      end
      free = !m_valid || rdy;
      fire = 0;
      if (m_q.size() == DEPTH) begin
         m_idle = 0;
         if (rdy) begin
            foreach (m_out[i]) m_out[i] = m_q[i];
            m_valid = 1;
            m_q.delete();
            if (dv) m_q.push_back(d);
         end else if (dv) begin
            m_ovf = 1;
         end
         return;
      end
`ifdef SIPO_TIMEOUT_EN
      if (m_q.size() > 0 && !dv) begin
         m_idle++;
         if (m_idle == int'(TIMEOUT)) begin
            fire   = 1;
            m_idle = 0;
         end
      end else begin
         m_idle = 0;
      end
`endif
      if (m_valid && rdy) m_valid = 0;
      if (fl || fire) begin
         m_q.delete();
      end else if (dv) begin
         m_q.push_back(d);
         if (m_q.size() == DEPTH && free) begin
            foreach (m_out[i]) m_out[i] = m_q[i];
            m_valid = 1;
            m_q.delete();
         end
      end
   endfunction

   // Drive one cycle of inputs, advance the model, settle past the edge.
   task automatic step(input bit rst_n, input bit dv, input bit fl, input bit rdy,
                       input logic [WIDTH-1:0] d);
      nRST       = rst_n;
      DIN_VALID  = dv;
      FLUSH      = fl;
      DOUT_READY = rdy;
      DIN        = d;
      @(posedge CLK);
      model_edge(rst_n, dv, fl, rdy, d);
      #1;
   endtask

   task automatic test_reset();
      step(0, 0, 0, 0, '0);
      step(0, 1, 0, 1, '1);
      checks++;
      if (DOUT_VALID !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", DOUT_VALID);
      end
      checks++;
      if (WORD_CNT !== '0) begin
         errors++; $display("FAIL reset_cnt: got %0d expected 0", WORD_CNT);
      end
      checks++;
      if (OVERFLOW !== 1'b0) begin
         errors++; $display("FAIL reset_ovf: got %b expected 0", OVERFLOW);
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         checks++;
         if (DOUT[i] !== '0) begin
            errors++; $display("FAIL reset_dout[%0d]: got %h expected 0", i, DOUT[i]);
         end
      end
   endtask

   task automatic test_basic_frame();
      logic [CW-1:0] exp_cnt;
      step(0, 0, 0, 1, '0);
      for (int i = 1; i <= int'(DEPTH); i++) begin
         step(1, 1, 0, 1, pat(i));
         exp_cnt = (i == int'(DEPTH)) ? CW'(0) : CW'(i);
         checks++;
         if (WORD_CNT !== exp_cnt) begin
            errors++; $display("FAIL basic_cnt word %0d: got %0d expected %0d", i, WORD_CNT, exp_cnt);
         end
         checks++;
         if (DOUT_VALID !== (i == int'(DEPTH))) begin
            errors++; $display("FAIL basic_valid word %0d: got %b", i, DOUT_VALID);
         end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         checks++;
         if (DOUT[i] !== pat(i + 1)) begin
            errors++; $display("FAIL basic_dout[%0d]: got %h expected %h", i, DOUT[i], pat(i + 1));
         end
      end
      step(1, 0, 0, 1, '0);
      checks++;
      if (DOUT_VALID !== 1'b0 || DOUT[0] !== pat(1)) begin
         errors++; $display("FAIL basic_release: valid %b dout0 %h expected 0 / %h", DOUT_VALID, DOUT[0], pat(1));
      end
   endtask

   task automatic test_backpressure();
      step(0, 0, 0, 0, '0);
      for (int i = 1; i <= 8; i++) step(1, 1, 0, 0, 64'(i));
      for (int i = 0; i < int'(DEPTH); i++) begin
         checks++;
         if (DOUT[i] !== 64'(i + 1)) begin
            errors++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, DOUT[i], 64'(i + 1));
         end
      end
      checks++;
      if (WORD_CNT !== CW'(DEPTH) || DOUT_VALID !== 1'b1) begin
         errors++; $display("FAIL bp_full: cnt %0d valid %b expected %0d / 1", WORD_CNT, DOUT_VALID, DEPTH);
      end
      step(1, 0, 0, 1, '0);
      for (int i = 0; i < int'(DEPTH); i++) begin
         checks++;
         if (DOUT[i] !== 64'(i + 5)) begin
            errors++; $display("FAIL bp_second[%0d]: got %h expected %h", i, DOUT[i], 64'(i + 5));
         end
      end
      checks++;
      if (DOUT_VALID !== 1'b1 || OVERFLOW !== 1'b0 || WORD_CNT !== '0) begin
         errors++; $display("FAIL bp_after: valid %b ovf %b cnt %0d expected 1/0/0", DOUT_VALID, OVERFLOW, WORD_CNT);
      end
   endtask

   task automatic test_overflow();
      step(0, 0, 0, 0, '0);
      for (int i = 1; i <= 8; i++) step(1, 1, 0, 0, 64'(i));
      step(1, 1, 0, 0, 64'(9));
      checks++;
      if (OVERFLOW !== 1'b1 || WORD_CNT !== CW'(DEPTH)) begin
         errors++; $display("FAIL ovf_set: ovf %b cnt %0d expected 1 / %0d", OVERFLOW, WORD_CNT, DEPTH);
      end
      step(1, 1, 0, 1, 64'(10));
      checks++;
      if (WORD_CNT !== CW'(1) || DOUT[DEPTH-1] !== 64'(8)) begin
         errors++; $display("FAIL ovf_resume: cnt %0d dout3 %h expected 1 / 8", WORD_CNT, DOUT[DEPTH-1]);
      end
      for (int i = 11; i <= 13; i++) step(1, 1, 0, 1, 64'(i));
      for (int i = 0; i < int'(DEPTH); i++) begin
         checks++;
         if (DOUT[i] !== 64'(i + 10)) begin
            errors++; $display("FAIL ovf_frame[%0d]: got %h expected %h", i, DOUT[i], 64'(i + 10));
         end
      end
      checks++;
      if (OVERFLOW !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky: got %b expected 1", OVERFLOW);
      end
   endtask

   task automatic test_flush();
      step(0, 0, 0, 1, '0);
      step(1, 1, 0, 1, 64'h1);
      step(1, 1, 0, 1, 64'h2);
      step(1, 1, 1, 1, 64'h3);
      checks++;
      if (WORD_CNT !== '0 || OVERFLOW !== 1'b0 || DOUT_VALID !== 1'b0) begin
         errors++; $display("FAIL flush_clear: cnt %0d ovf %b valid %b expected 0/0/0", WORD_CNT, OVERFLOW, DOUT_VALID);
      end
      for (int i = 0; i < int'(DEPTH); i++) step(1, 1, 0, 1, 64'hA + 64'(i));
      for (int i = 0; i < int'(DEPTH); i++) begin
         checks++;
         if (DOUT[i] !== 64'hA + 64'(i)) begin
            errors++; $display("FAIL flush_frame[%0d]: got %h expected %h", i, DOUT[i], 64'hA + 64'(i));
         end
      end
      // A complete frame waiting for the consumer is not flushable.
      for (int i = 1; i <= 8; i++) step(1, 1, 0, 0, 64'(i));
      step(1, 0, 1, 0, '0);
      checks++;
      if (WORD_CNT !== CW'(DEPTH)) begin
         errors++; $display("FAIL flush_fullwait: cnt %0d expected %0d", WORD_CNT, DEPTH);
      end
   endtask

   task automatic test_reset_mid();
      step(0, 0, 0, 1, '0);
      for (int i = 1; i <= 3; i++) step(1, 1, 0, 1, pat(i));
      step(0, 0, 0, 1, '0);
      checks++;
      if (WORD_CNT !== '0 || DOUT_VALID !== 1'b0 || OVERFLOW !== 1'b0 || DOUT[0] !== '0) begin
         errors++; $display("FAIL rstmid_zero: cnt %0d valid %b ovf %b dout0 %h expected all 0",
                            WORD_CNT, DOUT_VALID, OVERFLOW, DOUT[0]);
      end
      for (int i = 5; i <= 8; i++) step(1, 1, 0, 1, pat(i));
      for (int i = 0; i < int'(DEPTH); i++) begin
         checks++;
         if (DOUT[i] !== pat(i + 5)) begin
            errors++; $display("FAIL rstmid_frame[%0d]: got %h expected %h", i, DOUT[i], pat(i + 5));
         end
      end
   endtask

`ifdef SIPO_TIMEOUT_EN
   task automatic test_timeout();
      step(0, 0, 0, 1, '0);
      step(1, 1, 0, 1, 64'h71);
      step(1, 1, 0, 1, 64'h72);
      for (int i = 0; i < int'(TIMEOUT) - 1; i++) step(1, 0, 0, 1, '0);
      checks++;
      if (WORD_CNT !== CW'(2)) begin
         errors++; $display("FAIL timeout_early: cnt %0d expected 2", WORD_CNT);
      end
      step(1, 0, 0, 1, '0);
      checks++;
      if (WORD_CNT !== '0) begin
         errors++; $display("FAIL timeout_fire: cnt %0d expected 0", WORD_CNT);
      end
      for (int i = 0; i < int'(DEPTH); i++) step(1, 1, 0, 1, 64'h80 + 64'(i));
      for (int i = 0; i < int'(DEPTH); i++) begin
         checks++;
         if (DOUT[i] !== 64'h80 + 64'(i)) begin
            errors++; $display("FAIL timeout_frame[%0d]: got %h expected %h", i, DOUT[i], 64'h80 + 64'(i));
         end
      end
   endtask
`endif

   task automatic test_random();
      bit dv, fl, rdy;
      logic [WIDTH-1:0] d;
      step(0, 0, 0, 0, '0);
      for (int n = 0; n < 3000; n++) begin
         dv  = ($urandom_range(0, 99) < 70);
         fl  = ($urandom_range(0, 99) < 4);
         rdy = ($urandom_range(0, 99) < 55);
         d   = {$urandom, $urandom};
         // Occasional long idle stretches exercise the partial-frame hold.
         if ((n % 500) > 480) dv = 0;
         step(1, dv, fl, rdy, d);
         checks++;
         if (DOUT_VALID !== m_valid || WORD_CNT !== CW'(m_q.size()) || OVERFLOW !== m_ovf) begin
            errors++; $display("FAIL rand_ctrl cyc %0d: valid %b cnt %0d ovf %b expected %b %0d %b",
                               n, DOUT_VALID, WORD_CNT, OVERFLOW, m_valid, m_q.size(), m_ovf);
         end
         for (int i = 0; i < int'(DEPTH); i++) begin
            checks++;
            if (DOUT[i] !== m_out[i]) begin
               errors++; $display("FAIL rand_dout[%0d] cyc %0d: got %h expected %h", i, n, DOUT[i], m_out[i]);
            end
         end
      end
   endtask

   initial begin
      nRST       = 1'b0;
      DIN_VALID  = 1'b0;
      FLUSH      = 1'b0;
      DOUT_READY = 1'b0;
      DIN        = '0;
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_overflow();
      test_flush();
      test_reset_mid();
`ifdef SIPO_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_shift_reg_1x64_to_4x64_sipo
